decode_ex_latch: RTL and testbench
==================================

# decode_ex_latch

Parametrised ID/EX pipeline latch with a built-in hazard unit. It sits between decode and execute in the pipelined datapath. It captures the decoded control and operands, inserts bubbles on load-use (or any RAW, without forwarding), and honours branch flushes and memory stalls. It also registers forwarding selects for the EX operand muxes and counts hazard bubbles.

## Interface
- DATA_W, 32, width of nPC, rdat1, rdat2, imm
- REG_AW, 5, register address width
- SHAMT_W, 5, shift-amount width
- ALUOP_W, 4, ALU opcode width
- COUNT_W, 16, bubble counter width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous active-high reset
- ihit  in  1  fetch delivered a valid instruction this cycle
- dstall  in  1  memory stage waiting on dhit; freeze latch
- flush  in  1  branch/jump taken in EX; squash
- valid_in, halt_in, regWr_in, dREN_in, dWEN_in  in  1 each  decoded controls
- rs_in, rt_in, regDst_in  in  REG_AW  source/dest registers
- ALUOp_in  in  ALUOP_W; ALUSrc_in, regSel_in, PCSrc_in  in  2 each
- nPC_in, rdat1_in, rdat2_in, imm_in  in  DATA_W
- shamt_in  in  SHAMT_W
- mem_regWr  in  1; mem_regDst  in  REG_AW  instruction currently in MEM
- *_ex  out  same widths as *_in  registered copies of every *_in field
- valid_ex  out  1  EX holds a real instruction
- fwdA_ex, fwdB_ex  out  2 each  operand select: 00 regfile, 01 from MEM, 10 from WB
- stall  out  1  combinational; hold PC and IF/ID
- bubble_cnt  out  COUNT_W  hazard bubbles inserted, saturating

## Operation
- Reset: every *_ex field is 0, including valid_ex and halt_ex. fwdA_ex and fwdB_ex are 00. bubble_cnt is 0.
- A bubble sets all *_ex control fields and valid_ex to 0. Data fields take don't-care values; the implementation zeroes them.
- Load-use hazard (lu):
  - Condition: valid_in & valid_ex & dREN_ex & regDst_ex≠0 & (regDst_ex==rs_in | regDst_ex==rt_in).
- Each edge resolves in this priority order:
  1. **flush:** insert a bubble.
  2. **dstall:** hold all *_ex.
  3. **hazard:** insert a bubble and increment bubble_cnt.
  4. **ihit:** load all *_in into *_ex.
  5. **else:** insert a bubble.
- stall = hazard & ~flush.
  - dstall does not assert stall; the upstream freezes on dstall itself.
- Forwarding selects are computed at load time for the instruction being loaded:
  - fwdA = 01 if regWr_ex & valid_ex & regDst_ex≠0 & regDst_ex==rs_in.
  - Else fwdA = 10 if mem_regWr & mem_regDst≠0 & mem_regDst==rs_in.
  - Else fwdA = 00.
  - fwdB uses the same rule on rt_in.
  - The younger producer (EX) wins when both match.
- Halt: halt_ex is sticky once a valid halt loads. After that, ihit loads are ignored and bubbles are inserted. It clears only on RST or flush.
- bubble_cnt saturates at all-ones; it never wraps.

## Timing
- Load latency: 1 cycle, *_in to *_ex.
- stall depends combinationally on *_in and the EX registers; there is no input-to-output register path.
- Load-use gives exactly one bubble.
  - Cycle n: stall=1 and a bubble enters EX.
  - Cycle n+1: the load has left EX, so lu=0 and the instruction loads with fwd=10 (WB path).
- flush and hazard in the same cycle: a bubble is inserted, stall=0, and the counter does not increment.
- dstall and flush together: flush wins.
- RST asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- DECODE_FWD_EN defined (default build):
  - Forwarding selects are generated as above.
  - Only load-use stalls.
- DECODE_FWD_EN undefined:
  - fwdA_ex and fwdB_ex are tied to 00.
  - hazard becomes any RAW: valid_in and a rs_in/rt_in match against regDst_ex (regWr_ex & valid_ex) or against mem_regDst (mem_regWr). Register 0 is excluded.
  - The register file's write-before-read covers WB.
  - Each stalled cycle increments bubble_cnt.

## Test plan
- Reset then idle: assert RST mid-load; all *_ex are 0 immediately, and with ihit=0 the outputs stay 0 afterwards.
- Load-use: lw $3 is in EX (dREN_ex=1, regDst_ex=3); add with rs_in=3 and ihit=1 → stall=1 for 1 cycle and valid_ex=0. The next cycle loads the add with fwdA_ex=10; bubble_cnt=1.
- Double forward: regDst_ex=5 (regWr) and mem_regDst=5; load rs_in=5, rt_in=5 → fwdA_ex=fwdB_ex=01. With rs_in=0 matching regDst_ex=0 → fwdA_ex=00.
- Flush vs hazard: flush=1 with a load-use condition present → valid_ex=0, stall=0, bubble_cnt unchanged.
- dstall hold: dstall=1 for 3 cycles with changing *_in → *_ex are unchanged; on release the current *_in loads.
- Halt/saturation: after a halt loads, further ihit loads are ignored. Forcing 2^COUNT_W+2 hazards leaves bubble_cnt at 0xFFFF. With DECODE_FWD_EN undefined, a MEM-stage RAW yields stall=1.

Source files
------------

// File: rtl/decode_ex_latch.sv
// ID/EX pipeline latch with hazard detection, bubble insertion, forwarding selects and a bubble counter.
// Build macro: DECODE_FWD_EN enables forwarding selects (only load-use stalls); without it every RAW stalls.
module decode_ex_latch #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int SHAMT_W = 5,
    parameter int ALUOP_W = 4,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dstall,
    input  logic               flush,
    input  logic               valid_in,
    input  logic               halt_in,
    input  logic               regWr_in,
    input  logic               dREN_in,
    input  logic               dWEN_in,
    input  logic [REG_AW-1:0]  rs_in,
    input  logic [REG_AW-1:0]  rt_in,
    input  logic [REG_AW-1:0]  regDst_in,
    input  logic [ALUOP_W-1:0] ALUOp_in,
    input  logic [1:0]         ALUSrc_in,
    input  logic [1:0]         regSel_in,
    input  logic [1:0]         PCSrc_in,
    input  logic [DATA_W-1:0]  nPC_in,
    input  logic [DATA_W-1:0]  rdat1_in,
    input  logic [DATA_W-1:0]  rdat2_in,
    input  logic [DATA_W-1:0]  imm_in,
    input  logic [SHAMT_W-1:0] shamt_in,
    input  logic               mem_regWr,
    input  logic [REG_AW-1:0]  mem_regDst,
    output logic               valid_ex,
    output logic               halt_ex,
    output logic               regWr_ex,
    output logic               dREN_ex,
    output logic               dWEN_ex,
    output logic [REG_AW-1:0]  rs_ex,
    output logic [REG_AW-1:0]  rt_ex,
    output logic [REG_AW-1:0]  regDst_ex,
    output logic [ALUOP_W-1:0] ALUOp_ex,
    output logic [1:0]         ALUSrc_ex,
    output logic [1:0]         regSel_ex,
    output logic [1:0]         PCSrc_ex,
    output logic [DATA_W-1:0]  nPC_ex,
    output logic [DATA_W-1:0]  rdat1_ex,
    output logic [DATA_W-1:0]  rdat2_ex,
    output logic [DATA_W-1:0]  imm_ex,
    output logic [SHAMT_W-1:0] shamt_ex,
    output logic [1:0]         fwdA_ex,
    output logic [1:0]         fwdB_ex,
    output logic               stall,
    output logic [COUNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic               valid;
        logic               halt;
        logic               regwr;
        logic               dren;
        logic               dwen;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  regdst;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         alusrc;
        logic [1:0]         regsel;
        logic [1:0]         pcsrc;
        logic [DATA_W-1:0]  npc;
        logic [DATA_W-1:0]  rdat1;
        logic [DATA_W-1:0]  rdat2;
        logic [DATA_W-1:0]  imm;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         fwda;
        logic [1:0]         fwdb;
    } ex_t;

    localparam logic [REG_AW-1:0]  REG_ZERO = {REG_AW{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    ex_t                ex_q;
    ex_t                ex_d;
    ex_t                load_s;
    ex_t                bubble_s;
    logic [COUNT_W-1:0] bubble_cnt_q;
    logic [COUNT_W-1:0] bubble_cnt_d;
    logic               ex_hit_rs_s;
    logic               ex_hit_rt_s;
    logic               mem_hit_rs_s;
    logic               mem_hit_rt_s;
    logic               hazard_s;

    // Youngest producer wins: EX result over the one already in MEM.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        logic [1:0] sel;
        if (ex_hit) begin
            sel = 2'b01;
        end else if (mem_hit) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Register-match terms against the EX and MEM producers.
    always_comb begin
        ex_hit_rs_s  = ex_q.valid & ex_q.regwr & (ex_q.regdst != REG_ZERO) & (ex_q.regdst == rs_in);
        ex_hit_rt_s  = ex_q.valid & ex_q.regwr & (ex_q.regdst != REG_ZERO) & (ex_q.regdst == rt_in);
        mem_hit_rs_s = mem_regWr & (mem_regDst != REG_ZERO) & (mem_regDst == rs_in);
        mem_hit_rt_s = mem_regWr & (mem_regDst != REG_ZERO) & (mem_regDst == rt_in);
    end

    // Hazard detection and the record that a load would capture.
    always_comb begin
        load_s        = '0;
        load_s.valid  = valid_in;
        load_s.halt   = halt_in & valid_in;
        load_s.regwr  = regWr_in;
        load_s.dren   = dREN_in;
        load_s.dwen   = dWEN_in;
        load_s.rs     = rs_in;
        load_s.rt     = rt_in;
        load_s.regdst = regDst_in;
        load_s.aluop  = ALUOp_in;
        load_s.alusrc = ALUSrc_in;
        load_s.regsel = regSel_in;
        load_s.pcsrc  = PCSrc_in;
        load_s.npc    = nPC_in;
        load_s.rdat1  = rdat1_in;
        load_s.rdat2  = rdat2_in;
        load_s.imm    = imm_in;
        load_s.shamt  = shamt_in;
`ifdef DECODE_FWD_EN
        hazard_s = valid_in & ex_q.valid & ex_q.dren & (ex_q.regdst != REG_ZERO) &
                   ((ex_q.regdst == rs_in) | (ex_q.regdst == rt_in));
        load_s.fwda = fwd_sel(ex_hit_rs_s, mem_hit_rs_s);
        load_s.fwdb = fwd_sel(ex_hit_rt_s, mem_hit_rt_s);
`else
        // Without forwarding any pending write to a source stalls; WB is covered by the regfile.
        hazard_s = valid_in & (ex_hit_rs_s | ex_hit_rt_s | mem_hit_rs_s | mem_hit_rt_s);
        load_s.fwda = fwd_sel(1'b0, 1'b0);
        load_s.fwdb = fwd_sel(1'b0, 1'b0);
`endif
    end

    // Next EX contents and bubble count in priority order flush, dstall, hazard, ihit.
    always_comb begin
        bubble_s      = '0;
        bubble_s.halt = ex_q.halt;
        ex_d          = ex_q;
        bubble_cnt_d  = bubble_cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (dstall) begin
            ex_d = ex_q;
        end else if (hazard_s) begin
            ex_d = bubble_s;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + COUNT_W'(1);
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else if (ihit && !ex_q.halt) begin
            ex_d = load_s;
        end else begin
            ex_d = bubble_s;
        end
    end

    // EX register and bubble counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall      = hazard_s & ~flush;
    assign bubble_cnt = bubble_cnt_q;
    assign valid_ex   = ex_q.valid;
    assign halt_ex    = ex_q.halt;
    assign regWr_ex   = ex_q.regwr;
    assign dREN_ex    = ex_q.dren;
    assign dWEN_ex    = ex_q.dwen;
    assign rs_ex      = ex_q.rs;
    assign rt_ex      = ex_q.rt;
    assign regDst_ex  = ex_q.regdst;
    assign ALUOp_ex   = ex_q.aluop;
    assign ALUSrc_ex  = ex_q.alusrc;
    assign regSel_ex  = ex_q.regsel;
    assign PCSrc_ex   = ex_q.pcsrc;
    assign nPC_ex     = ex_q.npc;
    assign rdat1_ex   = ex_q.rdat1;
    assign rdat2_ex   = ex_q.rdat2;
    assign imm_ex     = ex_q.imm;
    assign shamt_ex   = ex_q.shamt;
    assign fwdA_ex    = ex_q.fwda;
    assign fwdB_ex    = ex_q.fwdb;

endmodule

// File: tb/tb_decode_ex_latch.sv
// Directed, table-driven bench for decode_ex_latch; expectations follow the DECODE_FWD_EN build mode.
module tb_decode_ex_latch;

`ifdef DECODE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dstall, flush, valid_in, halt_in, regWr_in, dREN_in, dWEN_in;
    logic [4:0]  rs_in, rt_in, regDst_in, mem_regDst, shamt_in;
    logic [3:0]  ALUOp_in;
    logic [1:0]  ALUSrc_in, regSel_in, PCSrc_in;
    logic [31:0] nPC_in, rdat1_in, rdat2_in, imm_in;
    logic        mem_regWr;
    logic        valid_ex, halt_ex, regWr_ex, dREN_ex, dWEN_ex, stall;
    logic [4:0]  rs_ex, rt_ex, regDst_ex, shamt_ex;
    logic [3:0]  ALUOp_ex;
    logic [1:0]  ALUSrc_ex, regSel_ex, PCSrc_ex, fwdA_ex, fwdB_ex;
    logic [31:0] nPC_ex, rdat1_ex, rdat2_ex, imm_ex;
    logic [15:0] bubble_cnt;

    int tests = 0;
    int fails = 0;

    decode_ex_latch dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dstall(dstall), .flush(flush),
        .valid_in(valid_in), .halt_in(halt_in), .regWr_in(regWr_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .rs_in(rs_in), .rt_in(rt_in), .regDst_in(regDst_in), .ALUOp_in(ALUOp_in),
        .ALUSrc_in(ALUSrc_in), .regSel_in(regSel_in), .PCSrc_in(PCSrc_in),
        .nPC_in(nPC_in), .rdat1_in(rdat1_in), .rdat2_in(rdat2_in), .imm_in(imm_in), .shamt_in(shamt_in),
        .mem_regWr(mem_regWr), .mem_regDst(mem_regDst),
        .valid_ex(valid_ex), .halt_ex(halt_ex), .regWr_ex(regWr_ex), .dREN_ex(dREN_ex), .dWEN_ex(dWEN_ex),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .regDst_ex(regDst_ex), .ALUOp_ex(ALUOp_ex),
        .ALUSrc_ex(ALUSrc_ex), .regSel_ex(regSel_ex), .PCSrc_ex(PCSrc_ex),
        .nPC_ex(nPC_ex), .rdat1_ex(rdat1_ex), .rdat2_ex(rdat2_ex), .imm_ex(imm_ex), .shamt_ex(shamt_ex),
        .fwdA_ex(fwdA_ex), .fwdB_ex(fwdB_ex), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit, flush, valid, regwr, dren;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rdat1;
        logic        mwr;
        logic [4:0]  mrd;
        logic        e_stall, e_valid;
        logic [4:0]  e_rd;
        logic [1:0]  e_fa, e_fb;
        logic [31:0] e_rdat1;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic ih, fl, v, rw, dr, input logic [4:0] rs, rt, rd,
                                input logic [31:0] d1, input logic mw, input logic [4:0] mr,
                                input logic es, ev, input logic [4:0] erd, input logic [1:0] efa, efb,
                                input logic [31:0] ed1, input logic [15:0] ec);
        vec_t t;
        t.ihit = ih; t.flush = fl; t.valid = v; t.regwr = rw; t.dren = dr;
        t.rs = rs; t.rt = rt; t.rd = rd; t.rdat1 = d1; t.mwr = mw; t.mrd = mr;
        t.e_stall = es; t.e_valid = ev; t.e_rd = erd; t.e_fa = efa; t.e_fb = efb;
        t.e_rdat1 = ed1; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b0; dstall = 1'b0; flush = 1'b0; valid_in = 1'b0; halt_in = 1'b0;
        regWr_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0;
        rs_in = 5'd0; rt_in = 5'd0; regDst_in = 5'd0; ALUOp_in = 4'd0;
        ALUSrc_in = 2'd0; regSel_in = 2'd0; PCSrc_in = 2'd0;
        nPC_in = 32'd0; rdat1_in = 32'd0; rdat2_in = 32'd0; imm_in = 32'd0; shamt_in = 5'd0;
        mem_regWr = 1'b0; mem_regDst = 5'd0;
    endtask

    task automatic instr(input logic rw, dr, input logic [4:0] rs, rt, rd, input logic [31:0] d1);
        ihit = 1'b1; valid_in = 1'b1; regWr_in = rw; dREN_in = dr;
        rs_in = rs; rt_in = rt; regDst_in = rd; rdat1_in = d1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        tick();
        tick();
        chk("reset_valid", valid_ex, 1'b0);
        chk("reset_halt", halt_ex, 1'b0);
        chk("reset_cnt", bubble_cnt, 16'd0);
        chk("reset_fwd", {fwdA_ex, fwdB_ex}, 4'd0);
        RST = 1'b0;

        // Load, then assert RST between clock edges while another load is pending.
        instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 32'hABCD);
        imm_in = 32'h1234; nPC_in = 32'h40;
        tick();
        chk("preload_valid", valid_ex, 1'b1);
        chk("preload_rdat1", rdat1_ex, 32'hABCD);
        instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd8, 32'h5555);
        #3;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", valid_ex, 1'b0);
        chk("async_rst_rd", regDst_ex, 5'd0);
        chk("async_rst_data", {rdat1_ex, imm_ex, nPC_ex}, 96'd0);
        idle();
        #1;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_valid", valid_ex, 1'b0);
            chk("idle_regwr", regWr_ex, 1'b0);
        end

        tbl[0] = mk(1,0,1,1,0, 5'd1,5'd2,5'd5, 32'h11, 0,5'd0, 0,1,5'd5, 2'd0,2'd0, 32'h11, 16'd0);
        tbl[1] = mk(1,0,1,1,0, 5'd5,5'd5,5'd6, 32'h22, 1,5'd5, !FWD, FWD, FWD ? 5'd6 : 5'd0,
                    FWD ? 2'd1 : 2'd0, FWD ? 2'd1 : 2'd0, FWD ? 32'h22 : 32'h0, FWD ? 16'd0 : 16'd1);
        tbl[2] = mk(1,0,1,1,0, 5'd6,5'd5,5'd0, 32'h33, 1,5'd5, !FWD, FWD, 5'd0,
                    FWD ? 2'd1 : 2'd0, FWD ? 2'd2 : 2'd0, FWD ? 32'h33 : 32'h0, FWD ? 16'd0 : 16'd2);
        tbl[3] = mk(1,0,1,1,0, 5'd0,5'd0,5'd7, 32'h44, 1,5'd0, 0,1,5'd7, 2'd0,2'd0, 32'h44,
                    FWD ? 16'd0 : 16'd2);
        tbl[4] = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 32'h0, 0,5'd0, 0,0,5'd0, 2'd0,2'd0, 32'h0,
                    FWD ? 16'd0 : 16'd2);
        tbl[5] = mk(1,0,1,1,1, 5'd1,5'd2,5'd3, 32'h55, 0,5'd0, 0,1,5'd3, 2'd0,2'd0, 32'h55,
                    FWD ? 16'd0 : 16'd2);
        tbl[6] = mk(1,0,1,1,0, 5'd3,5'd4,5'd9, 32'h66, 0,5'd0, 1,0,5'd0, 2'd0,2'd0, 32'h0,
                    FWD ? 16'd1 : 16'd3);
        tbl[7] = mk(1,0,1,1,0, 5'd3,5'd4,5'd9, 32'h66, 1,5'd3, !FWD, FWD, FWD ? 5'd9 : 5'd0,
                    FWD ? 2'd2 : 2'd0, 2'd0, FWD ? 32'h66 : 32'h0, FWD ? 16'd1 : 16'd4);
        tbl[8] = mk(1,0,1,1,1, 5'd0,5'd0,5'd3, 32'h77, 0,5'd0, 0,1,5'd3, 2'd0,2'd0, 32'h77,
                    FWD ? 16'd1 : 16'd4);
        tbl[9] = mk(1,1,1,1,0, 5'd3,5'd3,5'd9, 32'h88, 0,5'd0, 0,0,5'd0, 2'd0,2'd0, 32'h0,
                    FWD ? 16'd1 : 16'd4);

        for (int i = 0; i < 10; i++) begin
            idle();
            ihit = tbl[i].ihit; flush = tbl[i].flush; valid_in = tbl[i].valid;
            regWr_in = tbl[i].regwr; dREN_in = tbl[i].dren;
            rs_in = tbl[i].rs; rt_in = tbl[i].rt; regDst_in = tbl[i].rd; rdat1_in = tbl[i].rdat1;
            mem_regWr = tbl[i].mwr; mem_regDst = tbl[i].mrd;
            #2;
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
            tick();
            chk($sformatf("vec%0d_valid", i), valid_ex, tbl[i].e_valid);
            chk($sformatf("vec%0d_rd", i), regDst_ex, tbl[i].e_rd);
            chk($sformatf("vec%0d_fwd", i), {fwdA_ex, fwdB_ex}, {tbl[i].e_fa, tbl[i].e_fb});
            chk($sformatf("vec%0d_rdat1", i), rdat1_ex, tbl[i].e_rdat1);
            chk($sformatf("vec%0d_cnt", i), bubble_cnt, tbl[i].e_cnt);
        end

        // dstall holds EX for three cycles while the inputs keep changing.
        idle();
        instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd10, 32'hAA);
        tick();
        chk("dstall_pre_rd", regDst_ex, 5'd10);
        for (int k = 0; k < 3; k++) begin
            idle();
            instr(1'b1, 1'b0, 5'd0, 5'd0, 5'd11 + 5'(k), 32'hB0 + 32'(k));
            dstall = 1'b1;
            #2;
            chk("dstall_stall", stall, 1'b0);
            tick();
            chk("dstall_hold_rd", regDst_ex, 5'd10);
            chk("dstall_hold_rdat1", rdat1_ex, 32'hAA);
            chk("dstall_hold_valid", valid_ex, 1'b1);
        end
        idle();
        instr(1'b1, 1'b0, 5'd0, 5'd0, 5'd14, 32'hCC);
        tick();
        chk("dstall_release_rd", regDst_ex, 5'd14);
        chk("dstall_release_rdat1", rdat1_ex, 32'hCC);
        dstall = 1'b1;
        flush = 1'b1;
        tick();
        chk("dstall_flush_valid", valid_ex, 1'b0);

        // Halt is sticky until flush.
        idle();
        instr(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        halt_in = 1'b1;
        tick();
        chk("halt_load", {halt_ex, valid_ex}, 2'b11);
        idle();
        instr(1'b1, 1'b0, 5'd0, 5'd0, 5'd15, 32'hDD);
        tick();
        chk("halt_ignore", {halt_ex, valid_ex}, 2'b10);
        chk("halt_ignore_rd", regDst_ex, 5'd0);
        tick();
        chk("halt_ignore2", {halt_ex, valid_ex}, 2'b10);
        flush = 1'b1;
        tick();
        chk("halt_flush", {halt_ex, valid_ex}, 2'b00);
        flush = 1'b0;
        instr(1'b1, 1'b0, 5'd0, 5'd0, 5'd16, 32'hEE);
        tick();
        chk("post_halt_load", {valid_ex, regDst_ex}, {1'b1, 5'd16});

`ifdef DECODE_FWD_EN
        idle();
        instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0);
        tick();
        idle();
        instr(1'b1, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0);
        #2;
        chk("lu_rt_stall", stall, 1'b1);
        tick();
        chk("lu_rt_cnt", bubble_cnt, 16'd2);
        chk("lu_rt_valid", valid_ex, 1'b0);
`else
        // A RAW against MEM stalls every cycle; run past the counter range.
        idle();
        instr(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0);
        mem_regWr = 1'b1;
        mem_regDst = 5'd4;
        #2;
        chk("mem_raw_stall", stall, 1'b1);
        repeat (65538) tick();
        chk("sat_cnt", bubble_cnt, 16'hFFFF);
        chk("sat_valid", valid_ex, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
